// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared constants, slave address map and master FSM states for the read arbiter
package axi_arb_pkg;
    localparam int NUM_M_P     = 3;
    localparam int NUM_S_P     = 6;
    localparam int MIDX_BITS_P = 2;
    localparam int SIDX_BITS_P = 3;
    localparam int DUMMY_M     = NUM_M_P;
    localparam int DEF_S       = NUM_S_P;
    localparam int DUMMY_S     = NUM_S_P + 1;
    localparam logic [NUM_S_P-1:0][31:0] SLV_BEGIN = {
        32'h2000_0000, 32'h1001_0000, 32'h1002_0000,
        32'h0002_0000, 32'h0001_0000, 32'h0000_0000
    };
    localparam logic [NUM_S_P-1:0][31:0] SLV_END = {
        32'h201F_FFFF, 32'h1001_03FF, 32'h1002_03FF,
        32'h0002_FFFF, 32'h0001_FFFF, 32'h0000_3FFF
    };
    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;
endpackage

// File: rtl/axi_addr_decoder.sv
// axi_addr_decoder: maps a read address to its slave index, unmapped addresses go to the default slave
module axi_addr_decoder
    import axi_arb_pkg::*;
#(
    parameter int NUM_S     = NUM_S_P,
    parameter int SIDX_BITS = SIDX_BITS_P
) (
    input  logic [31:0]          addr,
    output logic [SIDX_BITS-1:0] sidx
);
    always_comb begin
        sidx = SIDX_BITS'(NUM_S);
        for (int s = 0; s < NUM_S; s++)
            if ((addr - SLV_BEGIN[s]) <= (SLV_END[s] - SLV_BEGIN[s])) sidx = SIDX_BITS'(s);
    end
endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: round-robin AR arbiter holding registered read-mux selects until each burst's last beat
module axi_read_arbiter
    import axi_arb_pkg::*;
#(
    parameter int NUM_M     = NUM_M_P,
    parameter int NUM_S     = NUM_S_P,
    parameter int MIDX_BITS = MIDX_BITS_P,
    parameter int SIDX_BITS = SIDX_BITS_P
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [NUM_M-1:0][31:0]          ARADDR_M,
    input  logic [NUM_M-1:0]                ARVALID_M,
    input  logic [NUM_S:0]                  ARREADY_S,
    input  logic [NUM_S:0]                  RVALID_S,
    input  logic [NUM_S:0]                  RLAST_S,
    input  logic [NUM_M-1:0]                RREADY_M,
    output logic [NUM_S:0][MIDX_BITS-1:0]   SRIdx,
    output logic [NUM_M-1:0][SIDX_BITS-1:0] MRIdx
);
    localparam logic [MIDX_BITS-1:0] M_IDLE = MIDX_BITS'(NUM_M);
    localparam logic [MIDX_BITS-1:0] M_LAST = MIDX_BITS'(NUM_M - 1);
    localparam logic [SIDX_BITS-1:0] S_IDLE = SIDX_BITS'(NUM_S + 1);
    logic [NUM_M-1:0][SIDX_BITS-1:0] dec;
    state_e                          state_q [NUM_M];
    state_e                          state_d [NUM_M];
    logic [NUM_S:0]                  lock_q, lock_d;
    logic [MIDX_BITS-1:0]            ptr_q, ptr_d;
    logic [NUM_S:0][MIDX_BITS-1:0]   sridx_q, sridx_d;
    logic [NUM_M-1:0][SIDX_BITS-1:0] mridx_q, mridx_d;
    logic [MIDX_BITS-1:0]            c;
    logic [SIDX_BITS-1:0]            t;
    logic                            found;
    for (genvar g = 0; g < NUM_M; g++) begin : g_dec
        axi_addr_decoder #(.NUM_S(NUM_S), .SIDX_BITS(SIDX_BITS)) u_dec (
            .addr (ARADDR_M[g]),
            .sidx (dec[g])
        );
    end
    // mridx_q doubles as the latched target slave of each busy master
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        ptr_d   = ptr_q;
        sridx_d = sridx_q;
        mridx_d = mridx_q;
        found   = 1'b0;
        t       = '0;
        for (int m = 0; m < NUM_M; m++) begin
            t = mridx_q[m];
            if (state_q[m] == ADDR && ARVALID_M[m] && ARREADY_S[t]) state_d[m] = DATA;
            if (state_q[m] == DATA && RVALID_S[t] && RREADY_M[m] && RLAST_S[t]) begin
                state_d[m] = IDLE;
                lock_d[t]  = 1'b0;
                sridx_d[t] = M_IDLE;
                mridx_d[m] = S_IDLE;
            end
        end
        c = ptr_q;
        for (int i = 0; i < NUM_M; i++) begin
            if (!found && state_q[c] == IDLE && ARVALID_M[c] && !lock_q[dec[c]]) begin
                found           = 1'b1;
                state_d[c]      = ADDR;
                lock_d[dec[c]]  = 1'b1;
                sridx_d[dec[c]] = c;
                mridx_d[c]      = dec[c];
                ptr_d           = (c == M_LAST) ? '0 : c + 1'b1;
            end
            c = (c == M_LAST) ? '0 : c + 1'b1;
        end
    end
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int m = 0; m < NUM_M; m++) state_q[m] <= IDLE;
            lock_q  <= '0;
            ptr_q   <= '0;
            sridx_q <= {(NUM_S + 1){M_IDLE}};
            mridx_q <= {NUM_M{S_IDLE}};
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            ptr_q   <= ptr_d;
            sridx_q <= sridx_d;
            mridx_q <= mridx_d;
        end
    end
    assign SRIdx = sridx_q;
    assign MRIdx = mridx_q;
endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb_axi_read_arbiter: directed checks of grant timing, round-robin order, decode map, locks and reset
module tb_axi_read_arbiter;
    logic             ACLK = 1'b0;
    logic             ARESET;
    logic [2:0][31:0] araddr;
    logic [2:0]       arvalid;
    logic [6:0]       arready;
    logic [6:0]       rvalid;
    logic [6:0]       rlast;
    logic [2:0]       rready;
    logic [6:0][1:0]  SRIdx;
    logic [2:0][2:0]  MRIdx;
    int               n_cmp = 0;
    int               n_err = 0;
    logic [31:0]      dec_addr [9];
    int               dec_exp  [9];

    axi_read_arbiter dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .ARADDR_M  (araddr),
        .ARVALID_M (arvalid),
        .ARREADY_S (arready),
        .RVALID_S  (rvalid),
        .RLAST_S   (rlast),
        .RREADY_M  (rready),
        .SRIdx     (SRIdx),
        .MRIdx     (MRIdx)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic finish_burst(input int m, input int s);
        tick();
        arvalid[m] = 1'b0;
        rvalid[s]  = 1'b1;
        rlast[s]   = 1'b1;
        tick();
        rvalid[s]  = 1'b0;
        rlast[s]   = 1'b0;
    endtask

    initial begin
        dec_addr = '{32'h0000_3FFF, 32'h0000_4000, 32'h0001_0000, 32'h0002_FFFF, 32'h1002_03FF,
                     32'h1002_0400, 32'h1001_0000, 32'h201F_FFFF, 32'h2020_0000};
        dec_exp  = '{0, 6, 1, 2, 3, 6, 4, 5, 6};
        ARESET = 1'b1;
        araddr = '0; arvalid = '0; arready = '1; rvalid = '0; rlast = '0; rready = '1;
        tick(); tick();
        ARESET = 1'b0;
        chk("reset_sr", SRIdx, {7{2'd3}});
        chk("reset_mr", MRIdx, {3{3'd7}});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_hold", {SRIdx, MRIdx}, {{7{2'd3}}, {3{3'd7}}});
        end
        // single burst, 4 beats
        araddr[0] = 32'h0002_0010; arvalid[0] = 1'b1;
        tick();
        chk("m0_dm_sr", SRIdx[2], 0);
        chk("m0_dm_mr", MRIdx[0], 2);
        tick();
        arvalid[0] = 1'b0; rvalid[2] = 1'b1;
        for (int b = 0; b < 3; b++) begin
            tick();
            chk("m0_dm_hold", {SRIdx[2], MRIdx[0]}, {2'd0, 3'd2});
        end
        rlast[2] = 1'b1;
        tick();
        rvalid[2] = 1'b0; rlast[2] = 1'b0;
        chk("m0_dm_rel_sr", SRIdx[2], 3);
        chk("m0_dm_rel_mr", MRIdx[0], 7);
        // same-slave conflict from pointer 0
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        araddr[0] = 32'h0001_0000; araddr[1] = 32'h0001_0000; arvalid[1:0] = 2'b11;
        tick();
        chk("conf_m0_sr", SRIdx[1], 0);
        chk("conf_m0_mr", MRIdx[0], 1);
        chk("conf_m1_wait", MRIdx[1], 7);
        finish_burst(0, 1);
        chk("conf_rel_sr", SRIdx[1], 3);
        chk("conf_rel_m1", MRIdx[1], 7);
        tick();
        chk("conf_m1_sr", SRIdx[1], 1);
        chk("conf_m1_mr", MRIdx[1], 1);
        finish_burst(1, 1);
        // pointer is 2 now: M2 beats M0
        araddr[0] = 32'h0; araddr[2] = 32'h0; arvalid[0] = 1'b1; arvalid[2] = 1'b1;
        tick();
        chk("ptr2_sr", SRIdx[0], 2);
        chk("ptr2_m0_wait", MRIdx[0], 7);
        finish_burst(2, 0);
        tick();
        chk("ptr0_m0_sr", SRIdx[0], 0);
        finish_burst(0, 0);
        // concurrent bursts, pointer 1
        araddr[0] = 32'h0000_0100; araddr[1] = 32'h2000_0100; arvalid[1:0] = 2'b11;
        tick();
        chk("conc_e1", {SRIdx[5], MRIdx[1], MRIdx[0]}, {2'd1, 3'd5, 3'd7});
        tick();
        arvalid[1] = 1'b0;
        chk("conc_e2", {SRIdx[0], MRIdx[0], SRIdx[5]}, {2'd0, 3'd0, 2'd1});
        tick();
        arvalid[0] = 1'b0; rvalid[5] = 1'b1; rvalid[0] = 1'b1; rlast[0] = 1'b1;
        tick();
        chk("conc_m0_rel", {SRIdx[0], MRIdx[0]}, {2'd3, 3'd7});
        chk("conc_m1_hold", {SRIdx[5], MRIdx[1]}, {2'd1, 3'd5});
        rvalid[0] = 1'b0; rlast[0] = 1'b0; rlast[5] = 1'b1; rready[1] = 1'b0;
        tick();
        chk("rready_stall", {SRIdx[5], MRIdx[1]}, {2'd1, 3'd5});
        rready[1] = 1'b1;
        tick();
        rvalid[5] = 1'b0; rlast[5] = 1'b0;
        chk("conc_m1_rel", {SRIdx[5], MRIdx[1]}, {2'd3, 3'd7});
        // default slave, address change in ADDR ignored
        araddr[2] = 32'h3000_0000; arvalid[2] = 1'b1;
        tick();
        araddr[2] = 32'h0;
        chk("def_m2", {SRIdx[6], MRIdx[2]}, {2'd2, 3'd6});
        tick();
        arvalid[2] = 1'b0;
        chk("def_m2_latched", MRIdx[2], 6);
        rvalid[6] = 1'b1; rlast[6] = 1'b1;
        tick();
        rvalid[6] = 1'b0; rlast[6] = 1'b0;
        chk("def_m2_rel", {SRIdx[6], MRIdx[2]}, {2'd3, 3'd7});
        rvalid[4] = 1'b1; rlast[4] = 1'b1;
        tick();
        rvalid[4] = 1'b0; rlast[4] = 1'b0;
        chk("stray_rvalid", {SRIdx, MRIdx}, {{7{2'd3}}, {3{3'd7}}});
        // default slave locked one master at a time, pointer 0
        araddr[0] = 32'h4000_0000; araddr[2] = 32'h3000_0000; arvalid[0] = 1'b1; arvalid[2] = 1'b1;
        tick();
        chk("deflock_m0", {SRIdx[6], MRIdx[0], MRIdx[2]}, {2'd0, 3'd6, 3'd7});
        finish_burst(0, 6);
        chk("deflock_rel", {SRIdx[6], MRIdx[2]}, {2'd3, 3'd7});
        tick();
        chk("deflock_m2", {SRIdx[6], MRIdx[2]}, {2'd2, 3'd6});
        finish_burst(2, 6);
        // decode boundaries
        for (int i = 0; i < 9; i++) begin
            araddr[0] = dec_addr[i]; arvalid[0] = 1'b1;
            tick();
            chk($sformatf("dec_%08h", dec_addr[i]), MRIdx[0], dec_exp[i]);
            chk($sformatf("dec_sr_%08h", dec_addr[i]), SRIdx[dec_exp[i]], 0);
            finish_burst(0, dec_exp[i]);
        end
        // reset mid-DATA on M1
        araddr[1] = 32'h0001_0000; arvalid[1] = 1'b1;
        tick();
        chk("rst_m1_grant", SRIdx[1], 1);
        tick();
        arvalid[1] = 1'b0; rvalid[1] = 1'b1;
        tick();
        chk("rst_m1_data", MRIdx[1], 1);
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0; rvalid[1] = 1'b0;
        chk("rst_mid_sr", SRIdx, {7{2'd3}});
        chk("rst_mid_mr", MRIdx, {3{3'd7}});
        araddr[1] = 32'h0002_0000; arvalid[1] = 1'b1;
        tick();
        chk("rst_regrant", {SRIdx[2], MRIdx[1]}, {2'd1, 3'd2});
        finish_burst(1, 2);
        chk("rst_final_rel", {SRIdx, MRIdx}, {{7{2'd3}}, {3{3'd7}}});
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
